// File: rtl/udp_csum_pkg.sv
// Shared types and constants for the UDP/IPv4 receive checksum checker.
package udp_csum_pkg;

  localparam int CSUM_W = 16;

  // Folded ones-complement sum of a packet whose checksum field is correct.
  localparam logic [CSUM_W-1:0] CSUM_OK = 16'hFFFF;

  // ACC_HI/ACC_LO alternate over the byte pairs, FOLD1/FOLD2 absorb the
  // residual carry, RESULT holds the verdict until it is consumed.
  typedef enum logic [2:0] {
    ACC_HI = 3'd0,
    ACC_LO = 3'd1,
    FOLD1  = 3'd2,
    FOLD2  = 3'd3,
    RESULT = 3'd4
  } state_t;

endpackage

// File: rtl/csum_add16.sv
// Combinational 16-bit adder with carry-in/carry-out, built from four
// chained 4-bit lookahead-carry slices (same slice as the TX generator).
module csum_add16
  import udp_csum_pkg::*;
(
  input  logic [CSUM_W-1:0] a,
  input  logic [CSUM_W-1:0] b,
  input  logic              cin,
  output logic [CSUM_W-1:0] sum,
  output logic              cout
);

  // Carry into each slice; c[4] is the final carry-out.
  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_slice
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] cc;

    assign g     = a[4*i +: 4] & b[4*i +: 4];
    assign p     = a[4*i +: 4] ^ b[4*i +: 4];
    assign cc[0] = c[i];
    assign cc[1] = g[0] | (p[0] & cc[0]);
    assign cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cc[0]);
    assign cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) |
                   (p[2] & p[1] & p[0] & cc[0]);
    assign cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
                   (p[3] & p[2] & p[1] & g[0]) | ((&p) & cc[0]);
    assign sum[4*i +: 4] = p ^ cc[3:0];
    assign c[i+1]        = cc[4];
  end

  assign cout = c[4];

endmodule

// File: rtl/udp_csum_check.sv
// Receive-side UDP/IPv4 checksum verifier. Pairs incoming bytes into
// big-endian words, accumulates a ones-complement sum on top of the
// pseudo-header seed, folds the residual carry and presents a held result.
// Optional build macro UDP_CSUM_ERRCNT_EN adds a saturating count of failed
// results on csum_err_cnt.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. s_axis_tvalid/tdata/tlast are owned by the sender and may stall
// freely; chk_valid/chk_sum/chk_ok are held unchanged until chk_ready.
module udp_csum_check
  import udp_csum_pkg::*;
(
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [CSUM_W-1:0] csum_seed,
  input  logic [7:0]        s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic              chk_valid,
  input  logic              chk_ready,
  output logic              chk_ok,
  output logic [CSUM_W-1:0] chk_sum,
  output state_t            dbg_state
`ifdef UDP_CSUM_ERRCNT_EN
  ,
  output logic [15:0]       csum_err_cnt
`endif
);

  state_t            state, state_nxt;
  logic [CSUM_W-1:0] acc, acc_nxt;
  logic              carry, carry_nxt;
  logic [7:0]        hi, hi_nxt;
  logic              first, first_nxt;

  logic [CSUM_W-1:0] add_a, add_b, add_sum;
  logic              add_cin, add_cout;
  logic [CSUM_W-1:0] base_acc;
  logic              base_carry;

  // Single shared adder; the operand mux in the FSM picks word or zero.
  csum_add16 u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State and datapath registers; reset discards any partial sum.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= ACC_HI;
      acc   <= '0;
      carry <= 1'b0;
      hi    <= '0;
      first <= 1'b1;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      carry <= carry_nxt;
      hi    <= hi_nxt;
      first <= first_nxt;
    end
  end

  // Next-state, operand selection and input ready.
  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    carry_nxt     = carry;
    hi_nxt        = hi;
    first_nxt     = first;
    s_axis_tready = 1'b0;
    add_a         = acc;
    add_b         = '0;
    add_cin       = carry;
    // The first beat of a packet starts from the seed instead of acc.
    base_acc      = first ? csum_seed : acc;
    base_carry    = first ? 1'b0 : carry;

    case (state)
      ACC_HI: begin
        s_axis_tready = 1'b1;
        add_a         = base_acc;
        add_cin       = base_carry;
        add_b         = {s_axis_tdata, 8'h00};
        if (s_axis_tvalid) begin
          hi_nxt    = s_axis_tdata;
          first_nxt = 1'b0;
          if (s_axis_tlast) begin
            // Odd length: the lone high byte is summed with a zero pad.
            acc_nxt   = add_sum;
            carry_nxt = add_cout;
            state_nxt = FOLD1;
          end else begin
            acc_nxt   = base_acc;
            carry_nxt = base_carry;
            state_nxt = ACC_LO;
          end
        end
      end
      ACC_LO: begin
        s_axis_tready = 1'b1;
        add_b         = {hi, s_axis_tdata};
        if (s_axis_tvalid) begin
          acc_nxt   = add_sum;
          carry_nxt = add_cout;
          state_nxt = s_axis_tlast ? FOLD1 : ACC_HI;
        end
      end
      FOLD1: begin
        acc_nxt   = add_sum;
        carry_nxt = add_cout;
        state_nxt = FOLD2;
      end
      FOLD2: begin
        // Second fold covers FFFF + 1, which carries out once more.
        acc_nxt   = add_sum;
        carry_nxt = add_cout;
        state_nxt = RESULT;
      end
      RESULT: begin
        if (chk_ready) begin
          state_nxt = ACC_HI;
          first_nxt = 1'b1;
        end
      end
      default: state_nxt = ACC_HI;
    endcase
  end

  assign chk_valid = (state == RESULT);
  assign chk_sum   = chk_valid ? acc : '0;
  assign chk_ok    = chk_valid && (acc == CSUM_OK);
  assign dbg_state = state;

`ifdef UDP_CSUM_ERRCNT_EN
  // Saturating count of failed results, bumped on each consumed failure.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      csum_err_cnt <= '0;
    end else if (chk_valid && chk_ready && !chk_ok && (csum_err_cnt != 16'hFFFF)) begin
      csum_err_cnt <= csum_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_udp_csum_check.sv
// Self-checking bench for udp_csum_check: byte driver tasks, a ones-complement
// reference model, and a scoreboard queue drained by a result monitor.
module tb_udp_csum_check;
  import udp_csum_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [15:0] csum_seed;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic        chk_valid;
  logic        chk_ready;
  logic        chk_ok;
  logic [15:0] chk_sum;
  state_t      dbg_state;
`ifdef UDP_CSUM_ERRCNT_EN
  logic [15:0] csum_err_cnt;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_err = 0;
  logic [16:0] exp_q[$];
  logic [7:0]  pkt[$];
  logic [16:0] mon_e;
  logic [15:0] hold_sum;

  localparam logic [159:0] HDR_OK  = 160'h45000073_00004000_4011B861_C0A80001_C0A800C7;
  localparam logic [159:0] HDR_BAD = 160'h45000073_00004000_4011B862_C0A80001_C0A800C7;

  udp_csum_check dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .csum_seed     (csum_seed),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .chk_valid     (chk_valid),
    .chk_ready     (chk_ready),
    .chk_ok        (chk_ok),
    .chk_sum       (chk_sum),
    .dbg_state     (dbg_state)
`ifdef UDP_CSUM_ERRCNT_EN
    ,
    .csum_err_cnt  (csum_err_cnt)
`endif
  );

  // Clock / reset block
  always #5 sys_clk = ~sys_clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: full 32-bit sum of seed and big-endian words, then fold.
  function automatic logic [15:0] model_sum(input logic [15:0] seed, input logic [7:0] d[$]);
    logic [31:0] s;
    s = {16'h0, seed};
    for (int i = 0; i < d.size(); i += 2) begin
      logic [15:0] w;
      w[15:8] = d[i];
      w[7:0]  = (i + 1 < d.size()) ? d[i+1] : 8'h00;
      s = s + {16'h0, w};
    end
    while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return s[15:0];
  endfunction

  task automatic fill_pkt(input logic [255:0] bits, input int n);
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back(bits[8*(n-1-i) +: 8]);
  endtask

  // Driver: optional idle gap, then hold the byte until it is accepted.
  task automatic drive_byte(input logic [7:0] b, input logic last, input int gap);
    logic hs;
    int   cyc;
    repeat (gap) begin
      s_axis_tvalid = 1'b0;
      @(posedge sys_clk); #1;
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = b;
    s_axis_tlast  = last;
    hs  = 1'b0;
    cyc = 0;
    while (!hs && cyc < 50) begin
      @(negedge sys_clk);
      hs = s_axis_tready;
      @(posedge sys_clk); #1;
      cyc++;
    end
    if (!hs) chk_eq("tready_timeout", 32'(hs), 32'd1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Pushes the expected verdict, drives pkt, checks the fixed fold latency.
  // Returns at the negedge where RESULT is first visible.
  task automatic send_packet(input logic [15:0] seed, input int max_gap);
    logic [15:0] e;
    e = model_sum(seed, pkt);
    exp_q.push_back({e == 16'hFFFF, e});
    csum_seed = seed;
    for (int i = 0; i < pkt.size(); i++)
      drive_byte(pkt[i], i == pkt.size() - 1, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    @(negedge sys_clk); chk_eq("lat_fold1_valid", 32'(chk_valid), 32'd0);
    @(negedge sys_clk); chk_eq("lat_fold2_valid", 32'(chk_valid), 32'd0);
    @(negedge sys_clk); chk_eq("lat_result_valid", 32'(chk_valid), 32'd1);
  endtask

  task automatic finish_result();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      @(posedge sys_clk); #1;
      cyc++;
    end
    if (exp_q.size() != 0) begin
      chk_eq("result_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(posedge sys_clk); #1;
  endtask

  // Scoreboard monitor: pop and compare on every result handshake.
  always @(negedge sys_clk) begin
    if (!sys_rst && chk_valid && chk_ready) begin
      if (exp_q.size() == 0) begin
        chk_eq("unexpected_result", 32'(chk_sum), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk_eq("chk_sum", 32'(chk_sum), 32'(mon_e[15:0]));
        chk_eq("chk_ok", 32'(chk_ok), 32'(mon_e[16]));
        if (!mon_e[16]) exp_err++;
      end
    end
  end

  initial begin
    sys_rst       = 1'b1;
    csum_seed     = 16'h0;
    s_axis_tdata  = 8'h0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    chk_ready     = 1'b1;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk_eq("rst_tready", 32'(s_axis_tready), 32'd1);
    chk_eq("rst_valid", 32'(chk_valid), 32'd0);
    chk_eq("rst_ok", 32'(chk_ok), 32'd0);
    chk_eq("rst_sum", 32'(chk_sum), 32'd0);
    chk_eq("rst_state", 32'(dbg_state), 32'(ACC_HI));
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;

    // Valid IPv4 header, corrupted checksum, odd length.
    fill_pkt(256'(HDR_OK), 20);  send_packet(16'h0000, 0); finish_result();
    fill_pkt(256'(HDR_BAD), 20); send_packet(16'h0000, 0); finish_result();
    fill_pkt(256'h010203, 3);    send_packet(16'h0000, 0); finish_result();
`ifdef UDP_CSUM_ERRCNT_EN
    chk_eq("err_cnt_after_3", 32'(csum_err_cnt), 32'd2);
`endif

    // End-around carry from the seed, without and with tvalid gaps.
    fill_pkt(256'h0001, 2); send_packet(16'hFFFF, 0); finish_result();
    fill_pkt(256'h0001, 2); send_packet(16'hFFFF, 3); finish_result();

    // Random packets with random seeds and gaps.
    for (int k = 0; k < 6; k++) begin
      int n;
      n = int'($urandom_range(1, 16));
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back(8'($urandom_range(0, 255)));
      send_packet(16'($urandom_range(0, 65535)), 2);
      finish_result();
    end

    // Result held while chk_ready is low.
    chk_ready = 1'b0;
    fill_pkt(256'hABCD, 2);
    hold_sum = model_sum(16'h1234, pkt);
    send_packet(16'h1234, 0);
    repeat (5) begin
      chk_eq("hold_valid", 32'(chk_valid), 32'd1);
      chk_eq("hold_sum", 32'(chk_sum), 32'(hold_sum));
      chk_eq("hold_tready", 32'(s_axis_tready), 32'd0);
      @(negedge sys_clk);
    end
    @(posedge sys_clk); #1;
    chk_ready = 1'b1;
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    chk_eq("release_tready", 32'(s_axis_tready), 32'd1);
    chk_eq("release_valid", 32'(chk_valid), 32'd0);
    @(posedge sys_clk); #1;
    fill_pkt(256'hF0F0, 2); send_packet(16'h0F0F, 0); finish_result();

    // Reset mid-packet, then a clean header must still verify.
    fill_pkt(256'(HDR_OK), 20);
    for (int i = 0; i < 7; i++) drive_byte(pkt[i], 1'b0, 0);
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    exp_err = 0;
    @(negedge sys_clk);
    chk_eq("midrst_tready", 32'(s_axis_tready), 32'd1);
    chk_eq("midrst_valid", 32'(chk_valid), 32'd0);
    chk_eq("midrst_sum", 32'(chk_sum), 32'd0);
    @(posedge sys_clk); #1;
    send_packet(16'h0000, 0); finish_result();
`ifdef UDP_CSUM_ERRCNT_EN
    chk_eq("err_cnt_final", 32'(csum_err_cnt), 32'(exp_err));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
